// File: rtl/level_peak_encoder_pkg.sv
// Shared types and constant helpers for the level/peak encoder slice.
package level_peak_encoder_pkg;

    typedef enum logic [1:0] {
        TRACK = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } peak_state_t;

    // Smallest w with 2**w >= value; used only on elaboration-time constants.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/level_peak_encoder_prio.sv
// Combinational priority encoder: code = index+1 of the chosen set bit, 0 when no bit is set.
module prio_encoder_n
    import level_peak_encoder_pkg::*;
#(
    parameter int N_CH      = 7,
    parameter int PRIO_HIGH = 1,
    localparam int W        = clog2(N_CH + 1)
) (
    input  logic [N_CH-1:0] channel,
    output logic [W-1:0]    code
);

    // Scan order makes the last hit win: upward for highest, downward for lowest.
    always_comb begin
        code = '0;
        if (PRIO_HIGH != 0) begin
            for (int i = 0; i < N_CH; i++) begin
                if (channel[i]) begin
                    code = W'(i + 1);
                end
            end
        end else begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (channel[i]) begin
                    code = W'(i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/level_peak_encoder.sv
// Encodes sampled comparator flags into a level code and tracks a held, decaying peak.
//   state | meaning
//   TRACK | peak equals the most recent level, nothing held
//   HOLD  | peak frozen, hold_cnt counts down lower samples
//   DECAY | peak steps down by one per lower sample until it meets the level
module level_peak_encoder
    import level_peak_encoder_pkg::*;
#(
    parameter int N_CH        = 7,
    parameter int HOLD_CYCLES = 15,
    parameter int PRIO_HIGH   = 1,
    localparam int W          = clog2(N_CH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] channel,
    input  logic            sample_en,
    output logic [W-1:0]    level_out,
    output logic [W-1:0]    peak_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            overrun
);

    logic [W-1:0] code;
    logic [W-1:0] peak_dec;
    logic [7:0]   hold_cnt;
    peak_state_t  state;

    prio_encoder_n #(
        .N_CH      (N_CH),
        .PRIO_HIGH (PRIO_HIGH)
    ) u_enc (
        .channel (channel),
        .code    (code)
    );

    assign peak_dec = peak_out - W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_out <= '0;
            peak_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            hold_cnt  <= 8'd0;
            state     <= TRACK;
        end else begin
            overrun <= 1'b0;
            if (sample_en) begin
                level_out <= code;
                out_valid <= 1'b1;
                overrun   <= out_valid && !out_ready;
                if (code >= peak_out) begin
                    peak_out <= code;
                    hold_cnt <= 8'(HOLD_CYCLES);
                    // An equal level while tracking re-arms the hold but stays in TRACK.
                    state    <= (state == TRACK && code == peak_out) ? TRACK : HOLD;
                end else begin
                    case (state)
                        HOLD: begin
                            if (hold_cnt != 8'd0) begin
                                hold_cnt <= hold_cnt - 8'd1;
                            end
                            if (hold_cnt <= 8'd1) begin
                                state <= DECAY;
                            end
                        end
                        default: begin
                            // code < peak here, so peak_dec can never undershoot code.
                            peak_out <= peak_dec;
                            state    <= (peak_dec == code) ? TRACK : DECAY;
                        end
                    endcase
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
